// File: rtl/pipe_tx_data_unpacker_pkg.sv
// pipe_tx_data_unpacker_pkg: PIPE TxData width encoding, symbol struct and width helper.
package pipe_tx_data_unpacker_pkg;

   typedef enum int unsigned {
      BUS_WIDTH_8  = 8,
      BUS_WIDTH_16 = 16,
      BUS_WIDTH_32 = 32
   } pipe_data_width_t;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
   } pipe_sym_s;

   function automatic int unsigned pipe_bytes_per_word(pipe_data_width_t w);
      return (w == BUS_WIDTH_8) ? 1 : (w == BUS_WIDTH_16) ? 2 : 4;
   endfunction

endpackage

// File: rtl/pipe_tx_data_unpacker_word_buf.sv
// pipe_tx_word_buf: 2-entry word FIFO with registered ready and synchronous flush.
module pipe_tx_word_buf #(
   parameter int W = 36
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic [1:0]   count_o,
   output logic         ready_o
);

   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   count_q, count_d, slot;
   logic         ready_q, push, pop;

   assign push    = push_i && !flush_i;
   assign pop     = pop_i && !flush_i;
   // slot is where a push lands once this cycle's pop has taken effect
   assign slot    = count_q - {1'b0, pop};
   assign count_d = flush_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
   assign head_d  = (push && slot == 2'd0) ? wdata_i : pop ? tail_q : head_q;
   assign tail_d  = (push && slot == 2'd1) ? wdata_i : tail_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
         ready_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ready_q <= count_d != 2'd2;
      end
   end

   assign rdata_o = head_q;
   assign count_o = count_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/pipe_tx_data_unpacker.sv
// pipe_tx_data_unpacker: splits PIPE TxData/TxDataK words into one byte+K symbol per cycle, byte 0 first.
module pipe_tx_data_unpacker
   import pipe_tx_data_unpacker_pkg::*;
#(
   parameter pipe_data_width_t DATA_WIDTH = BUS_WIDTH_32,
   localparam int NB = pipe_bytes_per_word(DATA_WIDTH)
) (
   input  logic                  pclk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [NB-1:0]         tx_datak,
   input  logic                  tx_data_valid,
   output logic                  tx_ready,
   input  logic                  flush,
   output logic [7:0]            sym_data,
   output logic                  sym_k,
   output logic                  sym_valid,
   input  logic                  sym_ready,
   output logic                  sym_first
);

   localparam int DW = int'(DATA_WIDTH);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   if (DW != 8 * NB) begin : g_bad_width
      $error("pipe_tx_data_unpacker: DATA_WIDTH must be 8, 16 or 32");
   end

   logic [DW+NB-1:0] rdata;
   logic [1:0]       count;
   logic [IW-1:0]    idx_q, idx_d;
   logic             sym_xfer, pop;
   pipe_sym_s        sym;

   pipe_tx_word_buf #(.W(DW + NB)) u_buf (
      .clk_i   (pclk),
      .rst_ni  (reset_n),
      .push_i  (tx_data_valid && tx_ready),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i ({tx_datak, tx_data}),
      .rdata_o (rdata),
      .count_o (count),
      .ready_o (tx_ready)
   );

   assign sym_valid = count != 2'd0;
   assign sym_xfer  = sym_valid && sym_ready && !flush;
   // the word leaves the buffer only with its last byte; for NB=1 LAST is 0 so idx never moves
   assign pop       = sym_xfer && idx_q == LAST;
   assign idx_d     = flush ? '0 : !sym_xfer ? idx_q : (idx_q == LAST) ? '0 : idx_q + 1'b1;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) idx_q <= '0;
      else          idx_q <= idx_d;
   end

   assign sym.data  = 8'(rdata[DW-1:0] >> {idx_q, 3'b000});
   assign sym.k     = 1'(rdata[DW+NB-1:DW] >> idx_q);
   assign sym_data  = sym.data;
   assign sym_k     = sym.k;
   assign sym_first = idx_q == '0;

endmodule

// File: tb/tb_pipe_tx_data_unpacker.sv
// tb_pipe_tx_data_unpacker: directed and random traffic on 8/16/32-bit unpackers against a word-queue model.
module tb_pipe_tx_data_unpacker;
   import pipe_tx_data_unpacker_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   bit   fin = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_w
      localparam int W = 8 << g;
      localparam int N = W / 8;
      logic [W-1:0] tx_data = '0;
      logic [N-1:0] tx_datak = '0;
      logic         tx_data_valid = 1'b0;
      logic         flush = 1'b0;
      logic         sym_ready = 1'b0;
      logic         tx_ready, sym_k, sym_valid, sym_first;
      logic [7:0]   sym_data;
      bit           rnd_on = 1'b0;
      bit           done = 1'b0;
      logic [W-1:0] qd[$];
      logic [N-1:0] qk[$];
      int           ofs = 0;
      bit           armed = 1'b0;

      pipe_tx_data_unpacker #(.DATA_WIDTH(pipe_data_width_t'(W))) u_dut (
         .pclk          (clk),
         .reset_n       (reset_n),
         .tx_data       (tx_data),
         .tx_datak      (tx_datak),
         .tx_data_valid (tx_data_valid),
         .tx_ready      (tx_ready),
         .flush         (flush),
         .sym_data      (sym_data),
         .sym_k         (sym_k),
         .sym_valid     (sym_valid),
         .sym_ready     (sym_ready),
         .sym_first     (sym_first)
      );

      // Model: queue of pending words plus the number of bytes already sent from the oldest one.
      function automatic bit m_valid();
         return qd.size() != 0;
      endfunction
      function automatic bit m_ready();
         return armed && qd.size() < 2;
      endfunction
      function automatic logic [7:0] m_data();
         return 8'(qd[0] >> (8 * ofs));
      endfunction
      function automatic logic m_k();
         return 1'(qk[0] >> ofs);
      endfunction
      function automatic string tag(input string s);
         return $sformatf("w%0d_%s", W, s);
      endfunction

      initial forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            qd.delete();
            qk.delete();
            ofs = 0;
            armed = 1'b0;
         end else begin
            automatic bit acc = tx_data_valid && m_ready();
            automatic bit take = m_valid() && sym_ready;
            armed = 1'b1;
            if (flush) begin
               qd.delete();
               qk.delete();
               ofs = 0;
            end else begin
               if (take) begin
                  ofs++;
                  if (ofs == N) begin
                     ofs = 0;
                     void'(qd.pop_front());
                     void'(qk.pop_front());
                  end
               end
               if (acc) begin
                  qd.push_back(tx_data);
                  qk.push_back(tx_datak);
               end
            end
         end
      end

      initial forever begin
         @(negedge clk);
         if (!fin) begin
            chk(tag("tx_ready"), tx_ready, m_ready());
            chk(tag("sym_valid"), sym_valid, m_valid());
            chk(tag("sym_first"), sym_first, ofs == 0);
            if (m_valid()) begin
               chk(tag("sym_data"), sym_data, m_data());
               chk(tag("sym_k"), sym_k, m_k());
            end else if (!reset_n) begin
               chk(tag("reset_sym"), {sym_k, sym_data}, 0);
            end
         end
      end

      initial forever begin
         @(negedge reset_n);
         if ($time > 0) begin
            #1;
            chk(tag("async_rst_ready"), tx_ready, 0);
            chk(tag("async_rst_valid"), sym_valid, 0);
            chk(tag("async_rst_sym"), {sym_k, sym_data}, 0);
            chk(tag("async_rst_first"), sym_first, 1);
         end
      end

      initial forever begin
         @(posedge reset_n);
         #1;
         chk(tag("release_ready_low"), tx_ready, 0);
      end

      task automatic rnd(input int n);
         int lv[4];
         int pv, pr;
         lv = '{20, 50, 90, 100};
         pv = 50;
         pr = 50;
         rnd_on = 1'b1;
         for (int i = 0; i < n; i++) begin
            if (i % 64 == 0) begin
               pv = lv[$urandom_range(3)];
               pr = lv[$urandom_range(3)];
            end
            tx_data_valid = $urandom_range(99) < pv;
            tx_data       = W'($urandom);
            tx_datak      = N'($urandom);
            flush         = $urandom_range(63) == 0;
            sym_ready     = $urandom_range(99) < pr;
            step();
         end
         tx_data_valid = 1'b0;
         flush = 1'b0;
         done = 1'b1;
      endtask

      if (g == 0) begin : g_d8
         initial begin
            int sent, got;
            sent = 0;
            got = 0;
            @(posedge reset_n);
            step();
            for (int c = 0; c < 200 && got < 16; c++) begin
               tx_data_valid = sent < 16;
               tx_data       = 8'(8'h40 + sent);
               tx_datak      = 1'(sent % 3 == 0);
               sym_ready     = c % 2 == 0;
               @(negedge clk);
               if (sym_valid && sym_ready) begin
                  chk("w8_order", sym_data, 8'(8'h40 + got));
                  got++;
               end
               if (tx_data_valid && tx_ready) sent++;
               step();
            end
            chk("w8_all_bytes", got, 16);
            rnd(600);
         end
      end else if (g == 1) begin : g_d16
         initial begin
            logic [7:0] e[4];
            e = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
            @(posedge reset_n);
            step();
            sym_ready = 1'b1;
            tx_data = 16'hBBAA;
            tx_data_valid = 1'b1;
            step();
            for (int i = 0; i < 4; i++) begin
               tx_data_valid = i == 1;
               tx_data = 16'hDDCC;
               @(negedge clk);
               chk("w16_gapless_data", sym_data, e[i]);
               chk("w16_gapless_valid", sym_valid, 1);
               chk("w16_ready_held", tx_ready, 1);
               step();
            end
            rnd(600);
         end
      end else begin : g_d32
         initial begin
            logic [8:0] e[4];
            e = '{9'h111, 9'h022, 9'h033, 9'h044};
            @(posedge reset_n);
            step();
            sym_ready = 1'b1;
            tx_data = 32'h44332211;
            tx_datak = 4'b0001;
            tx_data_valid = 1'b1;
            step();
            tx_data_valid = 1'b0;
            chk("w32_model_byte0", m_data(), 8'h11);
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("w32_one_ksym", {sym_k, sym_data}, e[i]);
               chk("w32_one_first", sym_first, i == 0);
               step();
            end
            @(negedge clk);
            chk("w32_one_empty", sym_valid, 0);
            sym_ready = 1'b0;
            tx_datak = '0;
            tx_data = 32'h04030201;
            tx_data_valid = 1'b1;
            step();
            tx_data = 32'h08070605;
            step();
            tx_data = 32'h0c0b0a09;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("w32_stall_ready", tx_ready, 0);
               chk("w32_stall_hold", {sym_first, sym_data}, 9'h101);
               step();
            end
            tx_data_valid = 1'b0;
            sym_ready = 1'b1;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("w32_drain_order", sym_data, i + 1);
               step();
            end
            @(negedge clk);
            chk("w32_drain_empty", sym_valid, 0);
            tx_data = 32'h12345678;
            tx_data_valid = 1'b1;
            step();
            tx_data = 32'h9abcdef0;
            step();
            tx_data_valid = 1'b0;
            step();
            @(negedge clk);
            chk("w32_pre_flush_byte2", sym_data, 8'h34);
            flush = 1'b1;
            step();
            flush = 1'b0;
            @(negedge clk);
            chk("w32_flush_valid", sym_valid, 0);
            chk("w32_flush_ready", tx_ready, 1);
            tx_data = 32'hA5A5A5A5;
            tx_datak = 4'hF;
            tx_data_valid = 1'b1;
            step();
            tx_data_valid = 1'b0;
            @(negedge clk);
            chk("w32_after_flush", {sym_valid, sym_first, sym_k, sym_data}, 11'h7A5);
            repeat (4) step();
            rnd(600);
         end
      end
   end

   initial begin
      bit hit;
      hit = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         hit = g_w[0].rnd_on && g_w[1].rnd_on && g_w[2].rnd_on && g_w[2].sym_valid && !g_w[2].sym_first;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL mid_word_wait actual=timeout required=mid-word symbol on 32-bit unpacker");
      end else begin
         #3 reset_n = 1'b0;
         repeat (2) @(negedge clk);
         #2 reset_n = 1'b1;
      end
      hit = 1'b0;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         hit = g_w[0].done && g_w[1].done && g_w[2].done;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL stimulus_done actual=timeout required=all drivers finished");
      end
      fin = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_tx_data_unpacker.md
Name: pipe_tx_data_unpacker

Overview:
PHY-side receiver of the MAC-to-PHY PIPE transmit data bus.
- Accepts TxData/TxDataK words at the configured PIPE width (8/16/32 bits) from the MAC with a valid/ready handshake.
- Emits them one symbol (byte plus K flag) per cycle toward the PHY 8b/10b encoder / serializer.
- Complements the MAC-side width configuration defined in the shared PIPE package.

Parameters:
- DATA_WIDTH, BUS_WIDTH_32 (pipe_data_width_t), PIPE TxData width. Legal values are 8, 16 and 32; any other value is an elaboration error.
- NB (derived), DATA_WIDTH/8, number of bytes per word. Not overridable.

Ports:
- pclk  in  1  PIPE clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_WIDTH  MAC TxData word; byte i = bits [8i+7:8i].
- tx_datak  in  NB  per-byte K flag; bit i qualifies byte i.
- tx_data_valid  in  1  word present.
- tx_ready  out  1  unpacker can accept a word this cycle.
- flush  in  1  synchronous discard of all buffered data.
- sym_data  out  8  output symbol.
- sym_k  out  1  K flag for sym_data.
- sym_valid  out  1  symbol present.
- sym_ready  in  1  downstream accepts symbol.
- sym_first  out  1  sym_data is byte 0 of its word.

Behaviour:
- Input transfer: the unpacker accepts a word on a rising edge when tx_data_valid && tx_ready. Output transfer: a symbol is taken when sym_valid && sym_ready.
- Buffer: a 2-entry word FIFO with a count register (0..2). tx_ready is registered: tx_ready = (count_next < 2). Push and pop in the same cycle with count=2 is not possible, because ready is already 0 at count=2.
- Byte index register idx counts 0..NB-1:
  - sym_data = head[8*idx+7 : 8*idx]; sym_k = headk[idx]; sym_first = (idx==0); sym_valid = (count != 0).
  - On each output transfer: if idx == NB-1, then idx <= 0 and the head is popped; otherwise idx <= idx+1.
  - For NB=1, idx is held at 0 and every transfer pops.
- Byte order: bytes leave LSB-first (byte 0 first), matching PIPE lane byte order.
- Latency: a word accepted at edge t gives its byte 0 valid after edge t (cycle t+1) if the FIFO was empty. No combinational path from tx_* to sym_*.
- Throughput:
  - With sym_ready held high, the output runs at 1 symbol/cycle.
  - The MAC may supply a word every NB cycles without stalling.
  - For NB=1, a continuous 1 word/cycle with push and pop in the same cycle.
- Stall: while sym_valid && !sym_ready, sym_data, sym_k and sym_first stay stable. Upstream pushes continue until count=2.
- Simultaneous push and pop: count is unchanged. The pushed word enters the tail; head and idx update as above.
- flush: on the edge where flush=1:
  - count <= 0, idx <= 0, and any concurrent tx or sym transfer is ignored (not counted).
  - tx_ready is 1 on the next cycle.
- Reset (reset_n=0, asynchronous) clears count, idx and storage to 0.
  - Outputs during reset: tx_ready=0, sym_valid=0, sym_data=0, sym_k=0, sym_first=1.
  - tx_ready rises on the first edge after reset release.
  - Reset mid-word drops the partially sent word; no resumption.
- The only legal DATA_WIDTH change is at elaboration. No runtime width switch.

Decomposition:
- Shared package (common_pkg): pipe_data_width_t is used as-is. Add:
  - function pipe_bytes_per_word(pipe_data_width_t) returning 1/2/4;
  - typedef pipe_sym_s {logic [7:0] data; logic k;} for symbol-level interfaces.
- Sub-module pipe_tx_word_buf: the 2-entry FIFO parameterized on DATA_WIDTH+NB bits, with push/pop/flush/count and registered ready. The top level holds idx and the symbol mux.

Test Plan:
- DATA_WIDTH=32, one word 0x44332211 with k=4'b0001, sym_ready=1 -> 0x11(k=1, first=1), 0x22, 0x33, 0x44 (k=0) on cycles t+1..t+4; then sym_valid=0.
- DATA_WIDTH=16, continuous words 0xBBAA, 0xDDCC, one every 2 cycles, sym_ready=1 -> gapless AA, BB, CC, DD; tx_ready never drops.
- DATA_WIDTH=32, MAC pushes every cycle, sym_ready=0 -> tx_ready=0 after 2 accepts, sym_data held at byte 0. Release sym_ready -> 8 bytes in order, no loss or duplication.
- DATA_WIDTH=8, 16 back-to-back bytes with sym_ready toggling 1010 -> output order equals input order; count never exceeds 2.
- DATA_WIDTH=32, flush asserted after 2 of 4 bytes with a second word queued -> next cycle sym_valid=0, tx_ready=1. The next word 0xA5A5A5A5 emits from byte 0 with sym_first=1.
- Assert reset_n=0 asynchronously mid-word -> all outputs take their reset values immediately. After release, tx_ready=1 after one edge and no stale bytes appear.
